// File: rtl/mul_result_out_if.sv
// Handshake bundle between the multiplier output stage and its neighbours:
// reg_in status/lock, multiplier core product, and the downstream result port.
interface mul_result_out_if #(
    parameter int WIDTH = 8
);
    logic                 changed;
    logic [2*WIDTH-1:0]   product;
    logic                 locked;
    logic [2*WIDTH-1:0]   p_out;
    logic                 p_valid;
    logic                 p_ready;
    logic [7:0]           result_cnt;

    // Output stage side
    modport master (
        input  changed, product, p_ready,
        output locked, p_out, p_valid, result_cnt
    );

    // Environment side (reg_in, multiplier core, downstream consumer)
    modport slave (
        output changed, product, p_ready,
        input  locked, p_out, p_valid, result_cnt
    );
endinterface

// File: rtl/mul_result_out.sv
// Output-side companion to reg_in: locks the operands on a change, waits
// LATENCY edges for the multiplier core to settle, captures the product and
// hands it downstream over valid/ready, counting delivered results.
module mul_result_out #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    mul_result_out_if.master        bus
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        VALID
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

    state_t             state;
    logic [3:0]         lat_cnt;
    logic               locked_q;
    logic               p_valid_q;
    logic [2*WIDTH-1:0] p_out_q;
    logic [7:0]         result_cnt_q;

    // Transaction FSM with registered lock, valid, data and result count
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            lat_cnt      <= '0;
            locked_q     <= 1'b0;
            p_valid_q    <= 1'b0;
            p_out_q      <= '0;
            result_cnt_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.changed) begin
                        state    <= WAIT;
                        locked_q <= 1'b1;
                        lat_cnt  <= '0;
                    end
                end
                WAIT: begin
                    lat_cnt <= lat_cnt + 4'd1;
                    if (lat_cnt == LAST_CNT) begin
                        p_out_q   <= bus.product;
                        p_valid_q <= 1'b1;
                        state     <= VALID;
                    end
                end
                VALID: begin
                    if (bus.p_ready) begin
                        p_valid_q    <= 1'b0;
                        locked_q     <= 1'b0;
                        result_cnt_q <= result_cnt_q + 8'd1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    locked_q  <= 1'b0;
                    p_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.locked     = locked_q;
    assign bus.p_valid    = p_valid_q;
    assign bus.p_out      = p_out_q;
    assign bus.result_cnt = result_cnt_q;

endmodule

// File: tb/tb_mul_result_out.sv
// Directed bench for mul_result_out with a behavioural reg_in and a
// LATENCY-deep multiplier pipeline around it.
module tb_mul_result_out;

    localparam int W   = 8;
    localparam int LAT = 4;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        int          stall;
        logic [15:0] exp_p;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul_result_out_if #(.WIDTH(W)) bus ();

    mul_result_out #(.WIDTH(W), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Behavioural reg_in plus multiplier core (product stable LAT edges after load)
    logic [W-1:0]   a_in, b_in, a_reg, b_reg;
    logic [2*W-1:0] pipe [LAT-1];

    always @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            for (int i = 0; i < LAT - 1; i++) pipe[i] <= '0;
        end else begin
            if (!bus.locked) begin
                a_reg <= a_in;
                b_reg <= b_in;
            end
            pipe[0] <= 16'(a_reg) * 16'(b_reg);
            for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign bus.changed = (a_in != a_reg) || (b_in != b_reg);
    assign bus.product = pipe[LAT-2];

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_cnt = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One full transaction from the IDLE state; stall = cycles of p_ready=0 after capture
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input int stall,
                           input int mid_a, input logic [15:0] exp_p);
        int   waits;
        int   lat;
        logic stable;
        a_in = a;
        b_in = b;
        bus.p_ready = (stall == 0);
        waits = 0;
        do begin
            tick();
            waits++;
        end while (!bus.locked && waits < 20);
        chk("start_edge", waits, 1);
        lat = 0;
        while (!bus.p_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("capture_latency", lat, LAT);
        chk("p_out", bus.p_out, exp_p);
        stable = 1'b1;
        for (int i = 0; i < stall; i++) begin
            if (i == 2 && mid_a >= 0) a_in = mid_a[7:0];
            tick();
            if (!bus.p_valid || bus.p_out !== exp_p || a_reg !== a || !bus.locked) stable = 1'b0;
        end
        if (stall > 0) chk("stall_stable", stable, 1);
        bus.p_ready = 1'b1;
        tick();
        exp_cnt++;
        chk("accept_valid", bus.p_valid, 0);
        chk("accept_locked", bus.locked, 0);
        chk("result_cnt", bus.result_cnt, exp_cnt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t       vecs [6];
        int         t;
        logic       seen;
        logic [7:0] ra, rb, pa, pb;

        vecs[0] = '{a: 8'd12,  b: 8'd10,  stall: 0, exp_p: 16'h0078};
        vecs[1] = '{a: 8'd1,   b: 8'd1,   stall: 0, exp_p: 16'd1};
        vecs[2] = '{a: 8'd0,   b: 8'd200, stall: 2, exp_p: 16'd0};
        vecs[3] = '{a: 8'd255, b: 8'd1,   stall: 1, exp_p: 16'd255};
        vecs[4] = '{a: 8'd128, b: 8'd2,   stall: 3, exp_p: 16'd256};
        vecs[5] = '{a: 8'd7,   b: 8'd9,   stall: 0, exp_p: 16'd63};

        a_in = '0;
        b_in = '0;
        bus.p_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        chk("reset_locked", bus.locked, 0);
        chk("reset_valid", bus.p_valid, 0);
        chk("reset_pout", bus.p_out, 0);
        chk("reset_cnt", bus.result_cnt, 0);
        rst = 1'b0;

        // Single product, then idle with unchanged operands
        run_txn(vecs[0].a, vecs[0].b, vecs[0].stall, -1, vecs[0].exp_p);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.p_valid || bus.locked) seen = 1'b1;
        end
        chk("idle_no_activity", seen, 0);
        chk("idle_cnt", bus.result_cnt, 1);

        for (int i = 1; i < 6; i++)
            run_txn(vecs[i].a, vecs[i].b, vecs[i].stall, -1, vecs[i].exp_p);

        // Backpressure with operand change during stall, then back-to-back start
        run_txn(8'd255, 8'd255, 10, 3, 16'hFE01);
        run_txn(8'd3, 8'd255, 0, -1, 16'd765);

        // Reset while VALID
        a_in = 8'd12;
        b_in = 8'd10;
        bus.p_ready = 1'b0;
        t = 0;
        while (!bus.p_valid && t < 20) begin
            tick();
            t++;
        end
        chk("pre_reset_valid", bus.p_valid, 1);
        chk("pre_reset_pout", bus.p_out, 16'h0078);
        rst = 1'b1;
        tick();
        chk("rst_valid_locked", bus.locked, 0);
        chk("rst_valid_valid", bus.p_valid, 0);
        chk("rst_valid_pout", bus.p_out, 0);
        chk("rst_valid_cnt", bus.result_cnt, 0);
        tick();
        rst = 1'b0;
        exp_cnt = '0;
        bus.p_ready = 1'b1;
        t = 0;
        while (!bus.p_valid && t < 20) begin
            tick();
            t++;
        end
        chk("post_reset_latency", t, LAT + 1);
        chk("post_reset_pout", bus.p_out, 16'h0078);
        tick();
        exp_cnt++;
        chk("post_reset_cnt", bus.result_cnt, exp_cnt);

        // Reset mid-WAIT at S+2
        a_in = 8'd5;
        b_in = 8'd6;
        tick();
        chk("midwait_start", bus.locked, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midwait_locked", bus.locked, 0);
        chk("midwait_valid", bus.p_valid, 0);
        chk("midwait_cnt", bus.result_cnt, 0);
        exp_cnt = '0;
        t = 0;
        while (!bus.p_valid && t < 20) begin
            tick();
            t++;
        end
        chk("midwait_fresh_latency", t, LAT + 1);
        chk("midwait_fresh_pout", bus.p_out, 16'd30);
        tick();
        exp_cnt++;
        chk("midwait_fresh_cnt", bus.result_cnt, exp_cnt);

        // Counter wrap: 256 random transactions from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = '0;
        pa = '0;
        pb = '0;
        for (int i = 0; i < 256; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if (ra == pa && rb == pb) ra = ra + 8'd1;
            run_txn(ra, rb, (i % 3 == 0) ? 1 : 0, -1, 16'(ra) * 16'(rb));
            pa = ra;
            pb = rb;
        end
        chk("wrap_cnt", bus.result_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mul_result_out.md
# mul_result_out

Output-side companion to the 8-bit multiplier's input register stage (`reg_in`). It watches the input stage's `changed` flag and starts a product capture when it is set. It drives `locked` back to the input stage so the operands stay frozen while the multiplier core settles and the result waits to be consumed. It then presents the product downstream through a valid/ready handshake and counts delivered results.

## Interface
- `WIDTH`, default 8: operand width; product width is 2*WIDTH.
- `LATENCY`, default 4: clock edges from operand registration to a stable `product`; legal range 1..15.
- `clk`  in  1: sole clock; all state updates on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `changed`  in  1: from `reg_in.changed`; high means the registered operands differ from the live inputs.
- `product`  in  2*WIDTH: multiplier core output, computed from the registered operands.
- `locked`  out  1: to `reg_in.locked`; high freezes the operand registers.
- `p_out`  out  2*WIDTH: captured product.
- `p_valid`  out  1: `p_out` holds an unconsumed result.
- `p_ready`  in  1: downstream accepts `p_out` on an edge where `p_valid && p_ready`.
- `result_cnt`  out  8: number of results delivered; wraps 255->0.

## Operation
- FSM states: IDLE, WAIT, VALID.
- IDLE: `locked`=0, `p_valid`=0. If `changed`=1 at an edge, go to WAIT, set `locked`<=1, and clear the latency counter to 0. On the same edge, `reg_in` (still unlocked) loads the new operands. These operands are frozen from the next edge on.
- WAIT: the counter increments once per edge. On the edge where the counter equals LATENCY-1:
  - `p_out`<=`product`
  - `p_valid`<=1
  - state goes to VALID.
  - Capture therefore occurs on the LATENCY-th edge after the start edge.
- VALID: `p_out` and `p_valid` stay stable while `p_ready`=0. On an edge with `p_ready`=1:
  - `p_valid`<=0
  - `locked`<=0
  - `result_cnt`<=`result_cnt`+1 (mod 256)
  - state goes to IDLE.
- `changed` is ignored in WAIT and VALID.
- `p_ready` is ignored outside VALID.
- `p_out` keeps its last captured value in IDLE and WAIT. It changes only on a capture edge.
- Counter width is 4 bits. The counter does not run in IDLE or VALID.
- `locked` is a registered output and equals (state != IDLE).
- `p_valid` is registered and never depends combinationally on `p_ready`.
- At top level, `reg_in`'s active-low reset is driven by `~rst`. `rst` is synchronous here, so the top level must hold `rst` for at least one `clk` edge.

## Timing
- Reset (`rst`=1 at an edge) sets: state IDLE, `locked`=0, `p_valid`=0, `p_out`=0, `result_cnt`=0, counter 0. This applies in any state, including mid-WAIT or mid-VALID; an in-flight result is discarded and not counted.
- `rst` has priority over `changed` and `p_ready` on the same edge.
- Start edge S (IDLE, `changed`=1): `locked`=1 from S.
- Capture edge S+LATENCY: `p_valid`=1 from S+LATENCY.
- Fastest accept edge is S+LATENCY+1, which returns to IDLE. The earliest new start is S+LATENCY+2, so the minimum period is LATENCY+2 cycles per result.
- Back-to-back operation: if the operands changed while locked, `changed` is still 1 on the first IDLE edge, and a new transaction starts immediately on that edge.
- If `changed`=0 in IDLE, the block stays idle indefinitely with outputs held.

## Test plan
- Reset: drive `rst`=1 for 2 edges while in VALID with `p_out`=0x0078. Required: `p_valid`=0, `locked`=0, `p_out`=0, `result_cnt`=0 after the first reset edge.
- Single product (LATENCY=4): a=12, b=10, `p_ready` held 1. Required:
  - `locked` rises at S.
  - `p_valid` rises at S+4 with `p_out`=120 (0x0078).
  - Accepted at S+5; `locked`=0 and `result_cnt`=1 after S+5.
- Backpressure: a=255, b=255, `p_ready`=0 for 10 cycles after capture, then 1. Required:
  - `p_out`=0xFE01 and `p_valid`=1 stable throughout the stall.
  - Operands frozen despite a changing to 3 during the stall.
  - One accept; then the next transaction starts on the first IDLE edge and yields 3*255=765.
- No-change idle: operands constant after one transaction, `p_ready`=1. Required: no further `p_valid` pulse; `result_cnt` stays 1 for 50 cycles.
- Counter wrap: 256 transactions with random operands, each compared against a*b. Required: `result_cnt` returns to 0 and no product mismatches.
- Reset mid-WAIT: assert `rst` at S+2. Required: no capture, `p_valid` never rises, `locked`=0 after the reset edge, and a fresh transaction after reset completes normally.
